// File: rtl/fifo_pixel_pkg.sv
// Shared types and constants for the FWFT FIFO pixel reader.
package fifo_pixel_pkg;

    typedef logic [7:0] pixel_t;
    typedef logic [15:0] pos_t;

    localparam int PIXEL_BITS = $bits(pixel_t);
    localparam int WORD_WIDTH = 32;
    localparam int LANE_BITS  = $clog2(WORD_WIDTH / PIXEL_BITS);

    // A one-lane word still needs a 1-bit lane index to stay legal.
    function automatic int lane_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_pixel_reader_pos.sv
// Raster position counters producing sof/eol/eof for the current pixel.
module pixel_pos_counter
    import fifo_pixel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic sof,
    output logic eol,
    output logic eof
);

    localparam pos_t X_LAST = pos_t'(IMG_WIDTH - 1);
    localparam pos_t Y_LAST = pos_t'(IMG_HEIGHT - 1);

    pos_t x;
    pos_t y;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign sof = (x == '0) && (y == '0);
    assign eol = (x == X_LAST);
    assign eof = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/fifo_pixel_reader.sv
// Pops packed words from an FWFT FIFO and streams them out one pixel per beat.
module fifo_pixel_reader
    import fifo_pixel_pkg::*;
#(
    parameter int PIXEL_WIDTH     = PIXEL_BITS,
    parameter int PIXELS_PER_WORD = WORD_WIDTH / PIXEL_BITS,
    parameter int IMG_WIDTH       = 640,
    parameter int IMG_HEIGHT      = 480
) (
    input  logic                                   clock,
    input  logic                                   reset,
    output logic                                   fifo_rd_en,
    input  logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] fifo_dout,
    input  logic                                   fifo_empty,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [PIXEL_WIDTH-1:0]                 out_pixel,
    output logic                                   out_sof,
    output logic                                   out_eol,
    output logic                                   out_eof,
    output logic [15:0]                            frame_count
);

    localparam int WW = PIXEL_WIDTH * PIXELS_PER_WORD;
    localparam int LB = lane_width(PIXELS_PER_WORD);
    localparam logic [LB-1:0] LANE_LAST = LB'(PIXELS_PER_WORD - 1);

    logic [WW-1:0]          word_q;
    logic                   word_valid;
    logic [LB-1:0]          lane;
    logic                   advance;
    logic                   last_lane;
    logic [PIXEL_WIDTH-1:0] lane_pixel;
    logic                   pos_sof;
    logic                   pos_eol;
    logic                   pos_eof;

    always_comb begin
        advance    = word_valid && (!out_valid || out_ready);
        last_lane  = (lane == LANE_LAST);
        lane_pixel = word_q[lane*PIXEL_WIDTH +: PIXEL_WIDTH];
        // Refill in the same cycle the last lane leaves, so words chain gaplessly.
        fifo_rd_en = !reset && !fifo_empty &&
                     (!word_valid || (advance && last_lane));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_q     <= '0;
            word_valid <= 1'b0;
            lane       <= '0;
        end else if (fifo_rd_en) begin
            word_q     <= fifo_dout;
            word_valid <= 1'b1;
            lane       <= '0;
        end else if (advance) begin
            if (last_lane) begin
                word_valid <= 1'b0;
                lane       <= '0;
            end else begin
                lane <= lane + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (advance) begin
            out_valid <= 1'b1;
            out_pixel <= lane_pixel;
            out_sof   <= pos_sof;
            out_eol   <= pos_eol;
            out_eof   <= pos_eof;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (out_valid && out_ready && out_eof) begin
            frame_count <= frame_count + 1'b1;
        end
    end

    pixel_pos_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .clock (clock),
        .reset (reset),
        .en    (advance),
        .sof   (pos_sof),
        .eol   (pos_eol),
        .eof   (pos_eof)
    );

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Bench: FIFO/stream model in queues, random and directed traffic.
module tb_fifo_pixel_reader;

    localparam int PW    = 8;
    localparam int PPW   = 4;
    localparam int W     = 8;
    localparam int H     = 2;
    localparam int FRAME = W * H;

    logic        clock = 1'b0;
    logic        reset;
    logic        fifo_rd_en;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pixel;
    logic        out_sof;
    logic        out_eol;
    logic        out_eof;
    logic [15:0] frame_count;

    always #5 clock = ~clock;

    fifo_pixel_reader #(
        .PIXEL_WIDTH     (PW),
        .PIXELS_PER_WORD (PPW),
        .IMG_WIDTH       (W),
        .IMG_HEIGHT      (H)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pixel   (out_pixel),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .out_eof     (out_eof),
        .frame_count (frame_count)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pos = 0;
    int frames_m = 0;
    int pops = 0;
    int delivered = 0;
    int t0;

    logic [31:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  lp[$];
    bit          ls[$];
    bit          le[$];
    bit          lf[$];
    int          lc[$];

    bit          held = 0;
    bit          strict = 0;
    bit          last_valid = 0;
    logic [10:0] hold_v;

    task automatic chk(input bit ok, input string name,
                       input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        for (int i = 0; i < PPW; i++)
            exp_q.push_back(w[i*PW +: PW]);
    endtask

    task automatic clear_log();
        lp.delete();
        ls.delete();
        le.delete();
        lf.delete();
        lc.delete();
        pops = 0;
    endtask

    // One cycle: drive at negedge, compare against model, commit at posedge.
    task automatic step(input bit rdy);
        bit acc;
        bit pop;
        bit es;
        bit ee;
        bit ef;
        @(negedge clock);
        cyc++;
        out_ready  = rdy;
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? 32'h0 : fifo_q[0];
        #1;
        chk(!(fifo_rd_en && fifo_empty), "rd_en_while_empty",
            fifo_rd_en, 0);
        chk(frame_count == 16'(frames_m), "frame_count",
            frame_count, frames_m);
        if (held)
            chk(out_valid &&
                {out_pixel, out_sof, out_eol, out_eof} == hold_v,
                "stall_hold",
                {out_valid, out_pixel, out_sof, out_eol, out_eof},
                {1'b1, hold_v});
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk(0, "spurious_pixel", out_pixel, 0);
            end else begin
                es = (pos == 0);
                ee = ((pos % W) == W - 1);
                ef = (pos == FRAME - 1);
                chk(out_pixel == exp_q[0], "pixel",
                    out_pixel, exp_q[0]);
                chk({out_sof, out_eol, out_eof} == {es, ee, ef},
                    "flags", {out_sof, out_eol, out_eof},
                    {es, ee, ef});
            end
        end
        if (strict && out_valid)
            chk(fifo_rd_en == (!fifo_empty && (delivered % PPW) == 2),
                "pop_phase", fifo_rd_en,
                !fifo_empty && (delivered % PPW) == 2);
        last_valid = out_valid;
        acc    = out_valid && out_ready;
        pop    = fifo_rd_en;
        held   = out_valid && !out_ready;
        hold_v = {out_pixel, out_sof, out_eol, out_eof};
        if (acc) begin
            lp.push_back(out_pixel);
            ls.push_back(out_sof);
            le.push_back(out_eol);
            lf.push_back(out_eof);
            lc.push_back(cyc);
        end
        @(posedge clock);
        if (pop && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        if (acc) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (pos == FRAME - 1) frames_m = (frames_m + 1) & 16'hFFFF;
            pos = (pos + 1) % FRAME;
            delivered++;
        end
    endtask

    // mode 0: ready always high, 1: toggling 1,0,..., 2: random
    task automatic run_until(input int n, input int bound,
                             input int mode);
        int k = 0;
        bit r;
        while (lp.size() < n && k < bound) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (k % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            step(r);
            k++;
        end
        chk(lp.size() >= n, "timeout", lp.size(), n);
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        reset = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        pos = 0;
        frames_m = 0;
        held = 0;
        strict = 0;
        delivered = 0;
        fifo_empty = 1'b0;
        fifo_dout = 32'hDEADBEEF;
        out_ready = 1'b1;
        repeat (n) begin
            #1;
            chk(fifo_rd_en == 0, "rd_en_in_reset", fifo_rd_en, 0);
            chk(out_valid == 0, "valid_in_reset", out_valid, 0);
            chk(frame_count == 0, "frames_in_reset", frame_count, 0);
            chk({out_pixel, out_sof, out_eol, out_eof} == 0,
                "outs_in_reset",
                {out_pixel, out_sof, out_eol, out_eof}, 0);
            @(negedge clock);
        end
        reset = 1'b0;
        fifo_empty = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int target;
        reset = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout = '0;
        out_ready = 1'b0;
        do_reset(3);

        // Straight line, no backpressure
        clear_log();
        t0 = cyc;
        push_word(32'h44332211);
        push_word(32'h88776655);
        run_until(8, 40, 0);
        for (int i = 0; i < 8 && i < lp.size(); i++) begin
            chk(lp[i] == 8'(8'h11 * (i + 1)), "line_pixel",
                lp[i], 8'(8'h11 * (i + 1)));
            chk(ls[i] == (i == 0), "line_sof", ls[i], i == 0);
            chk(le[i] == (i == 7), "line_eol", le[i], i == 7);
            chk(lc[i] == lc[0] + i, "line_no_bubble", lc[i], lc[0] + i);
        end
        if (lc.size() > 0)
            chk(lc[0] - t0 == 3, "first_latency", lc[0] - t0, 3);
        chk(pops == 2, "line_pops", pops, 2);

        // Backpressure toggling
        do_reset(2);
        clear_log();
        push_word(32'h44332211);
        push_word(32'h88776655);
        run_until(8, 60, 1);
        for (int i = 0; i < 8 && i < lp.size(); i++)
            chk(lp[i] == 8'(8'h11 * (i + 1)), "bp_pixel",
                lp[i], 8'(8'h11 * (i + 1)));

        // FIFO starvation mid-line
        do_reset(2);
        clear_log();
        push_word(32'h44332211);
        run_until(4, 40, 0);
        repeat (5) begin
            step(1'b1);
            chk(last_valid == 0, "gap_valid", last_valid, 0);
        end
        push_word(32'h88776655);
        run_until(8, 40, 0);
        if (lp.size() >= 8) begin
            chk(lp[4] == 8'h55, "starve_pixel", lp[4], 8'h55);
            chk(ls[4] == 0, "starve_sof", ls[4], 0);
            chk(le[3] == 0, "starve_eol3", le[3], 0);
            chk(le[7] == 1, "starve_eol7", le[7], 1);
        end

        // Full frame and wrap
        do_reset(2);
        clear_log();
        repeat (5) push_word($urandom);
        run_until(20, 80, 0);
        for (int i = 0; i < 20 && i < lf.size(); i++)
            chk(lf[i] == (i == 15), "frame_eof", lf[i], i == 15);
        if (ls.size() >= 17)
            chk(ls[16] == 1, "wrap_sof", ls[16], 1);
        #1;
        chk(frame_count == 16'd1, "frame_count_one", frame_count, 1);

        // Reset mid-frame
        do_reset(2);
        clear_log();
        repeat (4) push_word($urandom);
        run_until(5, 40, 0);
        do_reset(3);
        clear_log();
        push_word($urandom);
        run_until(1, 20, 0);
        if (ls.size() >= 1)
            chk(ls[0] == 1, "post_reset_sof", ls[0], 1);

        // Continuous words: pop alongside last-lane advance, no bubbles
        do_reset(2);
        clear_log();
        repeat (8) push_word($urandom);
        strict = 1;
        run_until(32, 60, 0);
        strict = 0;
        if (lc.size() >= 32)
            chk(lc[31] - lc[0] == 31, "stream_no_bubble",
                lc[31] - lc[0], 31);
        chk(pops == 8, "stream_pops", pops, 8);

        // Random traffic and backpressure
        do_reset(2);
        clear_log();
        repeat (400) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8)
                push_word($urandom);
            step(1'($urandom_range(0, 1)));
        end
        target = lp.size() + exp_q.size();
        run_until(target, 300, 2);
        chk(exp_q.size() == 0, "random_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
